sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds:
- any integer depth from 2 to 256, not only powers of two;
- run-time programmable almost-full/almost-empty thresholds;
- an occupancy count output;
- sticky overflow/underflow error flags;
- selectable show-ahead or registered read data.

It sits between bus-side logic (e.g. AHB/Wishbone front ends) and the SPI/QSPI engines, buffering command, write and read data.

---
 rtl/sync_fifo_prog_if.sv | 33 +++
 rtl/sync_fifo_prog.sv | 103 ++++++++++
 tb/tb_sync_fifo_prog.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog. The master side drives requests
// and thresholds; the slave side (the FIFO) returns data, flags and occupancy.
interface sync_fifo_prog_if #(
    parameter int W  = 8,
    parameter int DP = 16,
    parameter int CW = $clog2(DP + 1)
);
    logic          flush;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic [CW-1:0] afull_th;
    logic [CW-1:0] aempty_th;
    logic          err_clr;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [CW-1:0] level;
    logic          ovf;
    logic          udf;

    modport master (
        output flush, wr_en, wr_data, rd_en, afull_th, aempty_th, err_clr,
        input  rd_data, full, empty, afull, aempty, level, ovf, udf
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, afull_th, aempty_th, err_clr,
        output rd_data, full, empty, afull, aempty, level, ovf, udf
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of any depth 2..256 with programmable almost-full/empty thresholds,
// occupancy output, sticky overflow/underflow flags and optional registered read data.
module sync_fifo_prog #(
    parameter int W      = 8,
    parameter int DP     = 16,
    parameter int RD_REG = 0,
    parameter int CW     = $clog2(DP + 1)
) (
    input logic             clk,
    input logic             reset_n,
    sync_fifo_prog_if.slave fifo
);
    localparam int PW = $clog2(DP);
    localparam logic [CW-1:0] LP_FULL = CW'(DP);
    localparam logic [PW-1:0] LP_LAST = PW'(DP - 1);

    logic [W-1:0]  r_mem [DP];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_level;
    logic          r_ovf;
    logic          r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_set;
    logic w_udf_set;

    // Flags derive only from the registered level, never from wr_en/rd_en.
    always_comb begin
        w_full    = (r_level == LP_FULL);
        w_empty   = (r_level == '0);
        w_wr_acc  = fifo.wr_en && !w_full  && !fifo.flush;
        w_rd_acc  = fifo.rd_en && !w_empty && !fifo.flush;
        w_ovf_set = fifo.wr_en && w_full  && !fifo.flush;
        w_udf_set = fifo.rd_en && w_empty && !fifo.flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (fifo.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd_acc)
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~fifo.err_clr);
            r_udf <= w_udf_set | (r_udf & ~fifo.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= fifo.wr_data;
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [W-1:0] r_rd_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_rd_data <= '0;
                else if (w_rd_acc)
                    r_rd_data <= r_mem[r_rd_ptr];
            end

            assign fifo.rd_data = r_rd_data;
        end else begin : g_show_ahead
            assign fifo.rd_data = r_mem[r_rd_ptr];
        end
    endgenerate

    assign fifo.full   = w_full;
    assign fifo.empty  = w_empty;
    assign fifo.afull  = (fifo.afull_th != '0) && (r_level >= fifo.afull_th);
    assign fifo.aempty = (r_level <= fifo.aempty_th);
    assign fifo.level  = r_level;
    assign fifo.ovf    = r_ovf;
    assign fifo.udf    = r_udf;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: a DP=6 show-ahead instance and a DP=256
// registered-read instance, driven with directed vectors.
module tb_sync_fifo_prog;
    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q0[$];
    logic [31:0] q1[$];
    logic        p1 = 1'b0;

    sync_fifo_prog_if #(.W(8),  .DP(6))   f0 ();
    sync_fifo_prog_if #(.W(32), .DP(256)) f1 ();

    sync_fifo_prog #(.W(8), .DP(6), .RD_REG(0)) dut0 (
        .clk     (clk),
        .reset_n (rst0_n),
        .fifo    (f0)
    );

    sync_fifo_prog #(.W(32), .DP(256), .RD_REG(1)) dut1 (
        .clk     (clk),
        .reset_n (rst1_n),
        .fifo    (f1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Show-ahead: the head word is on rd_data in the cycle the read is accepted.
    always @(negedge clk) begin
        if (rst0_n && f0.rd_en && !f0.empty && !f0.flush) begin
            if (q0.size() == 0)
                chk("sb0_unexpected_read", 64'(f0.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("sb0_rd_data", 64'(f0.rd_data), 64'(q0.pop_front()));
        end
    end

    // Registered: data for a read accepted last cycle appears now.
    always @(negedge clk) begin
        if (p1) begin
            if (q1.size() == 0)
                chk("sb1_unexpected_read", 64'(f1.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("sb1_rd_data", 64'(f1.rd_data), 64'(q1.pop_front()));
        end
        p1 = rst1_n && f1.rd_en && !f1.empty && !f1.flush;
    end

    task automatic cyc0(input logic fl, input logic wr, input logic [7:0] wd,
                        input logic rd, input logic ec);
        f0.flush   = fl;
        f0.wr_en   = wr;
        f0.wr_data = wd;
        f0.rd_en   = rd;
        f0.err_clr = ec;
        @(posedge clk);
        #1;
        f0.flush   = 1'b0;
        f0.wr_en   = 1'b0;
        f0.rd_en   = 1'b0;
        f0.err_clr = 1'b0;
    endtask

    task automatic cyc1(input logic wr, input logic [31:0] wd, input logic rd);
        f1.wr_en   = wr;
        f1.wr_data = wd;
        f1.rd_en   = rd;
        @(posedge clk);
        #1;
        f1.wr_en = 1'b0;
        f1.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  d;
        logic [31:0] last;

        rst0_n = 1'b0;
        rst1_n = 1'b0;
        f0.flush = 1'b0; f0.wr_en = 1'b0; f0.wr_data = '0; f0.rd_en = 1'b0;
        f0.err_clr = 1'b0; f0.afull_th = 3'd4; f0.aempty_th = 3'd1;
        f1.flush = 1'b0; f1.wr_en = 1'b0; f1.wr_data = '0; f1.rd_en = 1'b0;
        f1.err_clr = 1'b0; f1.afull_th = '0; f1.aempty_th = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",  64'(f0.level), 64'd0);
        chk("rst_empty",  64'(f0.empty), 64'd1);
        chk("rst_full",   64'(f0.full), 64'd0);
        chk("rst_aempty", 64'(f0.aempty), 64'd1);
        chk("rst_afull",  64'(f0.afull), 64'd0);
        chk("rst_ovf",    64'(f0.ovf), 64'd0);
        chk("rst_udf",    64'(f0.udf), 64'd0);
        chk("rst1_rd_data", 64'(f1.rd_data), 64'd0);
        chk("rst1_empty", 64'(f1.empty), 64'd1);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        cyc0(0, 0, 8'h00, 0, 0);

        // Fill DP=6 with 0x10..0x15.
        for (int i = 0; i < 6; i++) begin
            d = 8'h10 + 8'(i);
            q0.push_back(d);
            cyc0(0, 1, d, 0, 0);
            chk("fill_level",  64'(f0.level), 64'(i + 1));
            chk("fill_full",   64'(f0.full), 64'(i == 5));
            chk("fill_afull",  64'(f0.afull), 64'(i + 1 >= 4));
            chk("fill_aempty", 64'(f0.aempty), 64'(i + 1 <= 1));
            chk("fill_empty",  64'(f0.empty), 64'd0);
        end
        chk("pre_ovf", 64'(f0.ovf), 64'd0);
        cyc0(0, 1, 8'h99, 0, 0);
        chk("ovf_level", 64'(f0.level), 64'd6);
        chk("ovf_set",   64'(f0.ovf), 64'd1);
        chk("ovf_full",  64'(f0.full), 64'd1);

        cyc0(0, 0, 8'h00, 1, 0);
        chk("drain_level5", 64'(f0.level), 64'd5);
        f0.afull_th = 3'd0;
        #1;
        chk("afull_th0_same_cycle", 64'(f0.afull), 64'd0);
        f0.afull_th = 3'd4;
        #1;
        chk("afull_th4_restored", 64'(f0.afull), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc0(0, 0, 8'h00, 1, 0);
            chk("drain_level",  64'(f0.level), 64'(4 - i));
            chk("drain_aempty", 64'(f0.aempty), 64'(4 - i <= 1));
        end
        chk("drain_empty", 64'(f0.empty), 64'd1);
        chk("drain_sb", 64'(q0.size()), 64'd0);

        // Alternating 3 writes / 3 reads across the 5->0 pointer wrap.
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 3; j++) begin
                d = 8'h40 + 8'(b * 3 + j);
                q0.push_back(d);
                cyc0(0, 1, d, 0, 0);
                chk("wrap_wr_level", 64'(f0.level), 64'(j + 1));
            end
            for (int j = 0; j < 3; j++) begin
                cyc0(0, 0, 8'h00, 1, 0);
                chk("wrap_rd_level", 64'(f0.level), 64'(2 - j));
            end
        end

        // Simultaneous read/write at level 3.
        for (int j = 0; j < 3; j++) begin
            d = 8'h60 + 8'(j);
            q0.push_back(d);
            cyc0(0, 1, d, 0, 0);
        end
        for (int j = 0; j < 8; j++) begin
            d = 8'h63 + 8'(j);
            q0.push_back(d);
            cyc0(0, 1, d, 1, 0);
            chk("both_level3", 64'(f0.level), 64'd3);
        end
        for (int j = 0; j < 3; j++) cyc0(0, 0, 8'h00, 1, 0);
        chk("both_drained", 64'(f0.level), 64'd0);

        cyc0(0, 0, 8'h00, 0, 1);
        chk("errclr_ovf", 64'(f0.ovf), 64'd0);
        chk("errclr_udf", 64'(f0.udf), 64'd0);

        // Both at level 0: write lands, read is an underflow.
        q0.push_back(8'h70);
        cyc0(0, 1, 8'h70, 1, 0);
        chk("both0_level", 64'(f0.level), 64'd1);
        chk("both0_udf",   64'(f0.udf), 64'd1);
        chk("both0_ovf",   64'(f0.ovf), 64'd0);
        for (int j = 1; j < 6; j++) begin
            d = 8'h70 + 8'(j);
            q0.push_back(d);
            cyc0(0, 1, d, 0, 0);
        end
        chk("both6_pre_full", 64'(f0.full), 64'd1);
        // Both at level 6: read taken, write rejected.
        cyc0(0, 1, 8'h7F, 1, 0);
        chk("both6_level", 64'(f0.level), 64'd5);
        chk("both6_ovf",   64'(f0.ovf), 64'd1);
        cyc0(0, 0, 8'h00, 1, 0);
        chk("preflush_level", 64'(f0.level), 64'd4);

        q0.delete();
        cyc0(1, 1, 8'hEE, 1, 0);
        chk("flush_level", 64'(f0.level), 64'd0);
        chk("flush_empty", 64'(f0.empty), 64'd1);
        chk("flush_ovf",   64'(f0.ovf), 64'd1);
        chk("flush_udf",   64'(f0.udf), 64'd1);

        cyc0(0, 0, 8'h00, 1, 1);
        chk("errclr_vs_udf_udf", 64'(f0.udf), 64'd1);
        chk("errclr_vs_udf_ovf", 64'(f0.ovf), 64'd0);

        q0.push_back(8'hA5);
        cyc0(0, 1, 8'hA5, 0, 0);
        chk("postflush_level", 64'(f0.level), 64'd1);
        chk("postflush_empty", 64'(f0.empty), 64'd0);
        cyc0(0, 0, 8'h00, 1, 0);
        chk("postflush_drain", 64'(f0.level), 64'd0);
        chk("sb0_final", 64'(q0.size()), 64'd0);

        // Registered read data, DP=256, W=32.
        for (int i = 0; i < 256; i++) begin
            q1.push_back(32'hA000_0000 + 32'(i));
            cyc1(1, 32'hA000_0000 + 32'(i), 0);
            if (i == 254) chk("big_full_at255", 64'(f1.full), 64'd0);
        end
        chk("big_full",  64'(f1.full), 64'd1);
        chk("big_level", 64'(f1.level), 64'd256);
        chk("big_afull_disabled", 64'(f1.afull), 64'd0);
        chk("big_rd_data_before_read", 64'(f1.rd_data), 64'd0);

        for (int k = 0; k < 10; k++) begin
            last = 32'hA000_0000 + 32'(k);
            cyc1(0, 32'h0, 1);
            for (int g = 0; g <= k % 3; g++) begin
                cyc1(0, 32'h0, 0);
                chk("big_rd_hold", 64'(f1.rd_data), 64'(last));
            end
        end
        chk("big_level_after", 64'(f1.level), 64'd246);

        rst1_n = 1'b0;
        q1.delete();
        #1;
        chk("async_rst_level",   64'(f1.level), 64'd0);
        chk("async_rst_empty",   64'(f1.empty), 64'd1);
        chk("async_rst_full",    64'(f1.full), 64'd0);
        chk("async_rst_rd_data", 64'(f1.rd_data), 64'd0);
        cyc1(0, 32'h0, 0);
        rst1_n = 1'b1;
        cyc1(0, 32'h0, 0);

        q1.push_back(32'h1234_5678);
        cyc1(1, 32'h1234_5678, 0);
        chk("big_post_rst_level", 64'(f1.level), 64'd1);
        cyc1(0, 32'h0, 1);
        cyc1(0, 32'h0, 0);
        chk("big_post_rst_hold", 64'(f1.rd_data), 64'h1234_5678);
        chk("sb1_final", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
